// File: rtl/sbox_chain_unwinder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sbox_chain_unwinder_pkg
// Purpose  : Shared state encoding, default whitening key and byte helper
//            for the S-box chain unwinder.
// Revision : 1.0 - initial release
// ============================================================================
package sbox_chain_unwinder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RUN  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

    localparam logic [31:0] c_DEFAULT_KEY = 32'hDEADC0DE;

    // Returns word with byte lane idx replaced by val.
    function automatic logic [31:0] put_byte(
        input logic [31:0] word,
        input logic [1:0]  idx,
        input logic [7:0]  val
    );
        logic [31:0] res;
        res = word;
        res[{idx, 3'b000} +: 8] = val;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_fwd_sbox_lut.sv
`default_nettype none
// ============================================================================
// Module   : aes_fwd_sbox_lut
// Purpose  : Purely combinational 256-entry AES forward S-box lookup.
// Revision : 1.0 - initial release
// ============================================================================
module aes_fwd_sbox_lut (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Ascending packed range: element 0 sits in the leftmost literal below.
    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_SBOX[i_byte];

endmodule
`default_nettype wire

// File: rtl/sbox_chain_unwinder.sv
`default_nettype none
// ============================================================================
// Module   : sbox_chain_unwinder
// Purpose  : Applies NUM_PASSES rounds of (forward AES S-box, XOR XOR_KEY) to
//            a 32-bit word, undoing an inverse-S-box target chain.
//            Build option SBOX_PARALLEL_EN: four S-box lanes, one pass per
//            cycle. Default: one S-box shared over the bytes, 4 cycles/pass.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_chain_unwinder
    import sbox_chain_unwinder_pkg::*;
#(
    parameter int          NUM_PASSES = 4,
    parameter logic [31:0] XOR_KEY    = c_DEFAULT_KEY
) (
    input  logic        ICE_CLK,
    input  logic        resetn,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam logic [3:0] c_LAST_PASS = 4'(NUM_PASSES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_work;
    logic [31:0] w_work_nxt;
    logic [3:0]  r_pass_cnt;
    logic [3:0]  w_pass_cnt_nxt;
    logic [1:0]  r_byte_idx;
    logic [1:0]  w_byte_idx_nxt;

    logic [31:0] w_sub_word;
    logic [31:0] w_step_word;
    logic        w_pass_end;

`ifdef SBOX_PARALLEL_EN
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        aes_fwd_sbox_lut u_sbox (
            .i_byte (r_work[8*gi +: 8]),
            .o_byte (w_sub_word[8*gi +: 8])
        );
    end

    assign w_pass_end  = 1'b1;
    assign w_step_word = w_sub_word ^ XOR_KEY;
`else
    logic [7:0] w_sub_byte;

    aes_fwd_sbox_lut u_sbox (
        .i_byte (r_work[{r_byte_idx, 3'b000} +: 8]),
        .o_byte (w_sub_byte)
    );

    // The whitening XOR lands together with the last byte of each pass.
    assign w_sub_word  = put_byte(r_work, r_byte_idx, w_sub_byte);
    assign w_pass_end  = (r_byte_idx == 2'd3);
    assign w_step_word = w_pass_end ? (w_sub_word ^ XOR_KEY) : w_sub_word;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_work_nxt     = r_work;
        w_pass_cnt_nxt = r_pass_cnt;
        w_byte_idx_nxt = r_byte_idx;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_work_nxt     = in_data;
                    w_pass_cnt_nxt = 4'd0;
                    w_byte_idx_nxt = 2'd0;
                    w_state_nxt    = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_work_nxt = w_step_word;
                if (w_pass_end) begin
                    w_byte_idx_nxt = 2'd0;
                    w_pass_cnt_nxt = r_pass_cnt + 4'd1;
                    if (r_pass_cnt == c_LAST_PASS) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end else begin
                    w_byte_idx_nxt = r_byte_idx + 2'd1;
                end
            end
            c_ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ICE_CLK) begin
        if (!resetn) begin
            r_state    <= c_ST_IDLE;
            r_work     <= 32'd0;
            r_pass_cnt <= 4'd0;
            r_byte_idx <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_work     <= w_work_nxt;
            r_pass_cnt <= w_pass_cnt_nxt;
            r_byte_idx <= w_byte_idx_nxt;
        end
    end

    // Ready is gated by resetn so it stays low for the whole reset window.
    assign in_ready  = resetn && (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);
    assign busy      = (r_state == c_ST_RUN) || (r_state == c_ST_DONE);
    assign out_data  = r_work;

endmodule
`default_nettype wire

// File: tb/tb_sbox_chain_unwinder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_chain_unwinder
// Purpose  : Directed self-checking bench; three unwinder instances with
//            different pass/key settings.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_chain_unwinder;

`ifdef SBOX_PARALLEL_EN
    localparam int c_LAT_PER_PASS = 1;
`else
    localparam int c_LAT_PER_PASS = 4;
`endif
    localparam logic [31:0] c_KEY = 32'hDEADC0DE;
    localparam int c_NP_MAIN = 4;
    localparam int c_LAT_MAIN = c_LAT_PER_PASS * c_NP_MAIN;

    logic            ICE_CLK;
    logic            resetn;
    logic [2:0][31:0] in_data;
    logic [2:0]      in_valid;
    logic [2:0]      in_ready;
    logic [2:0][31:0] out_data;
    logic [2:0]      out_valid;
    logic [2:0]      out_ready;
    logic [2:0]      busy;

    int n_vectors;
    int n_miscompares;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    // Instance 0: one pass, zero key. Instance 1: one pass, default key.
    // Instance 2: all defaults.
    sbox_chain_unwinder #(.NUM_PASSES(1), .XOR_KEY(32'h0)) u_dut0 (
        .ICE_CLK(ICE_CLK), .resetn(resetn),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .busy(busy[0])
    );
    sbox_chain_unwinder #(.NUM_PASSES(1)) u_dut1 (
        .ICE_CLK(ICE_CLK), .resetn(resetn),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .busy(busy[1])
    );
    sbox_chain_unwinder u_dut2 (
        .ICE_CLK(ICE_CLK), .resetn(resetn),
        .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .busy(busy[2])
    );

    initial ICE_CLK = 1'b0;
    always #5 ICE_CLK = ~ICE_CLK;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box derived from GF(2^8) inversion plus the AES affine map.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            fwd_tbl[a] = s;
            inv_tbl[s] = 8'(a);
        end
    endtask

    function automatic logic [31:0] fwd_model(input logic [31:0] w, input int np, input logic [31:0] key);
        for (int p = 0; p < np; p++) begin
            for (int b = 0; b < 4; b++) w[8*b +: 8] = fwd_tbl[w[8*b +: 8]];
            w = w ^ key;
        end
        return w;
    endfunction

    function automatic logic [31:0] inv_model(input logic [31:0] w, input int np, input logic [31:0] key);
        for (int p = 0; p < np; p++) begin
            w = w ^ key;
            for (int b = 0; b < 4; b++) w[8*b +: 8] = inv_tbl[w[8*b +: 8]];
        end
        return w;
    endfunction

    // Launches one word on instance d and waits (bounded) for out_valid.
    task automatic send_and_wait(input int d, input logic [31:0] w, output int lat, output logic [31:0] res);
        in_data[d]  = w;
        in_valid[d] = 1'b1;
        @(posedge ICE_CLK);
        #1 in_valid[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 200) begin
            @(posedge ICE_CLK);
            #1 lat++;
        end
        res = out_data[d];
    endtask

    int          lat;
    logic [31:0] res;
    logic [31:0] exp_word;
    logic [31:0] stim;
    int          n_ov;
    logic [31:0] b2b_words [4];
    int          k;
    int          nout;
    int          last_acc;
    logic        acc;
    logic        ov;
    logic [31:0] od;

    initial begin
        n_vectors = 0;
        n_miscompares = 0;
        build_tables();
        resetn    = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 3'b111;

        repeat (3) @(posedge ICE_CLK);
        #1;
        check_value("rst_in_ready", 64'(in_ready), 64'(3'b000));
        check_value("rst_out_valid", 64'(out_valid), 64'(3'b000));
        check_value("rst_busy", 64'(busy), 64'(3'b000));
        check_value("rst_out_data", 64'(out_data[2]), 64'h0);
        resetn = 1'b1;
        #1;
        check_value("post_rst_ready", 64'(in_ready), 64'(3'b111));
        @(posedge ICE_CLK); #1;

        // One pass, zero key: bare S-box.
        send_and_wait(0, 32'h00000000, lat, res);
        check_value("np1_k0_zero_lat", 64'(lat), 64'(c_LAT_PER_PASS));
        check_value("np1_k0_zero_data", 64'(res), 64'h63636363);
        @(posedge ICE_CLK); #1;
        send_and_wait(0, 32'h00010253, lat, res);
        check_value("np1_k0_bytes_data", 64'(res), 64'h637C77ED);
        @(posedge ICE_CLK); #1;
        send_and_wait(0, 32'hFF10C9A0, lat, res);
        check_value("np1_k0_high_data", 64'(res), 64'h16CADDE0);

        // One pass, default key.
        send_and_wait(1, 32'h00000000, lat, res);
        check_value("np1_key_zero_lat", 64'(lat), 64'(c_LAT_PER_PASS));
        check_value("np1_key_zero_data", 64'(res), 64'hBDCEA3BD);
        @(posedge ICE_CLK); #1;
        send_and_wait(1, 32'h00010253, lat, res);
        check_value("np1_key_bytes_data", 64'(res), 64'hBDD1B733);
        @(posedge ICE_CLK); #1;

        // Round trip through the inverse chain.
        stim = inv_model(32'hACE1ACE1, c_NP_MAIN, c_KEY);
        send_and_wait(2, stim, lat, res);
        check_value("roundtrip_lat", 64'(lat), 64'(c_LAT_MAIN));
        check_value("roundtrip_data", 64'(res), 64'hACE1ACE1);
        @(posedge ICE_CLK); #1;

        // Back-pressure in DONE with stray in_valid pulses.
        out_ready[2] = 1'b0;
        exp_word = fwd_model(32'h12345678, c_NP_MAIN, c_KEY);
        send_and_wait(2, 32'h12345678, lat, res);
        for (int i = 0; i < 10; i++) begin
            in_valid[2] = i[0];
            in_data[2]  = 32'hA5A50000 + 32'(i);
            check_value("hold_done", {30'd0, in_ready[2], out_valid[2], out_data[2]},
                        {30'd0, 1'b0, 1'b1, exp_word});
            @(posedge ICE_CLK); #1;
        end
        in_valid[2]  = 1'b1;
        in_data[2]   = 32'h0BADF00D;
        out_ready[2] = 1'b1;
        @(posedge ICE_CLK); #1;
        in_valid[2] = 1'b0;
        check_value("release_idle", {61'd0, in_ready[2], out_valid[2], busy[2]}, {61'd0, 3'b100});
        check_value("release_data", 64'(out_data[2]), 64'(exp_word));
        @(posedge ICE_CLK); #1;

        // Reset during pass 2 aborts the word.
        in_data[2]  = 32'h55AA33CC;
        in_valid[2] = 1'b1;
        @(posedge ICE_CLK);
        #1 in_valid[2] = 1'b0;
        repeat (c_LAT_PER_PASS + 1) @(posedge ICE_CLK);
        #1 resetn = 1'b0;
        @(posedge ICE_CLK);
        #1 resetn = 1'b1;
        check_value("abort_state", {31'd0, busy[2], out_data[2]}, 64'h0);
        n_ov = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid[2]) n_ov++;
            @(posedge ICE_CLK); #1;
        end
        check_value("abort_no_valid", 64'(n_ov), 64'h0);
        send_and_wait(2, 32'hCAFEBABE, lat, res);
        check_value("post_abort_lat", 64'(lat), 64'(c_LAT_MAIN));
        check_value("post_abort_data", 64'(res), 64'(fwd_model(32'hCAFEBABE, c_NP_MAIN, c_KEY)));
        @(posedge ICE_CLK); #1;

        // Back-to-back stream with in_valid held high.
        b2b_words[0] = 32'h00000000;
        b2b_words[1] = 32'h12345678;
        b2b_words[2] = 32'hFFFFFFFF;
        b2b_words[3] = 32'hACE1ACE1;
        k = 0; nout = 0; last_acc = -1;
        in_data[2]  = b2b_words[0];
        in_valid[2] = 1'b1;
        for (int c = 0; c < 400 && nout < 4; c++) begin
            acc = in_valid[2] & in_ready[2];
            ov  = out_valid[2];
            od  = out_data[2];
            @(posedge ICE_CLK); #1;
            if (ov) begin
                check_value("b2b_data", 64'(od), 64'(fwd_model(b2b_words[nout], c_NP_MAIN, c_KEY)));
                nout++;
            end
            if (acc) begin
                if (k > 0) check_value("b2b_period", 64'(c - last_acc), 64'(c_LAT_MAIN + 2));
                last_acc = c;
                k++;
                if (k < 4) in_data[2] = b2b_words[k];
                else in_valid[2] = 1'b0;
            end
        end
        in_valid[2] = 1'b0;
        check_value("b2b_accepts", 64'(k), 64'd4);
        check_value("b2b_outputs", 64'(nout), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
